sram_boot_loader: RTL
=====================

SRAM_BOOT_LOADER -- requirements
Module: sram_boot_loader

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data word width; only 32 is supported.
REQ-002 Parameter SRAM_ADDR_W, default 14, SHALL set the SRAM byte-address width; word address is SRAM_ADDR_W-2 bits.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 boot_start  input  1  one-cycle pulse that starts a boot; honoured only in IDLE, DONE or ERROR.
REQ-006 boot_nwords  input  SRAM_ADDR_W-2  image length in words, sampled on boot_start.
REQ-007 s_valid / s_data / s_ready  in / in[8] / out  byte stream from host loader; a byte transfers when s_valid and s_ready are both high.
REQ-008 i_valid / i_addr[SRAM_ADDR_W-2] / i_wdata[32] / i_wstrb[4]  outputs  SRAM instruction port request.
REQ-009 i_rdata[32] / i_ready  inputs  SRAM instruction port response; i_ready is asserted the cycle after an accepted i_valid.
REQ-010 cpu_i_valid / cpu_i_addr[SRAM_ADDR_W-2]  inputs  CPU instruction fetch request.
REQ-011 cpu_i_rdata[32] / cpu_i_ready  outputs  CPU fetch response.
REQ-012 cpu_rst_n  output  1  CPU reset; low until boot completes.
REQ-013 boot_busy / boot_done / boot_err  outputs  1 each  status flags.

Function
REQ-014 The FSM SHALL have the states IDLE, RECV, WRITE, CHECK, DONE and ERROR.
REQ-015 IDLE: on boot_start, latch boot_nwords, clear the word counter, byte counter and checksum, then go to RECV; if boot_nwords==0, go directly to CHECK.
REQ-016 RECV: s_ready=1; collect 4 bytes little-endian (first byte -> bits 7:0); after the 4th byte, go to WRITE on the next cycle.
REQ-017 WRITE: drive i_valid=1, i_wstrb=4'hF, i_addr=word counter, i_wdata=assembled word, s_ready=0; hold these until i_ready=1.
REQ-018 On i_ready in WRITE: deassert i_valid in the same cycle and increment the word counter; go to CHECK if counter+1==latched length, else RECV.
REQ-019 The word counter SHALL be SRAM_ADDR_W-2 bits; boot_nwords=2^(SRAM_ADDR_W-2)-1 SHALL fill to address max without wrap; no address above length-1 is written.
REQ-020 Minimum cost per word is 6 cycles (4 RECV, 1 WRITE issue, 1 ready).
REQ-021 DONE: cpu_rst_n=1, boot_done=1; i_valid=cpu_i_valid, i_addr=cpu_i_addr, i_wstrb=0, i_wdata=0, cpu_i_rdata=i_rdata, cpu_i_ready=i_ready (combinational pass-through).
REQ-022 Outside DONE: cpu_i_ready=0, cpu_i_rdata=0, and CPU requests are ignored.
REQ-023 ERROR: cpu_rst_n=0, boot_err=1, s_ready=0, i_valid=0.
REQ-024 boot_busy SHALL be 1 in RECV, WRITE and CHECK.
REQ-025 boot_start in DONE or ERROR re-enters the IDLE load action (reboot) and sets cpu_rst_n=0 the next cycle; boot_start in RECV, WRITE or CHECK SHALL be ignored.
REQ-026 Bytes presented while s_ready=0 SHALL NOT be consumed.

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously force state IDLE, all counters and the checksum to 0, and i_valid=0, s_ready=0, cpu_i_ready=0, cpu_i_rdata=0, cpu_rst_n=0, boot_busy=0, boot_done=0 and boot_err=0.
REQ-028 Reset asserted mid-boot SHALL abandon the boot; SRAM contents already written are left as they are.

Configuration
REQ-029 Macro BOOT_CHECKSUM_EN defined: the 8-bit modulo-256 sum of all image bytes is accumulated; CHECK consumes one extra stream byte and goes to DONE if it equals the sum, else ERROR.
REQ-030 Macro BOOT_CHECKSUM_EN undefined: CHECK SHALL go to DONE on the next cycle without consuming a byte; boot_err stays 0 and the ERROR state is unreachable.

Verification
REQ-031 boot_nwords=2, bytes 11 22 33 44 55 66 77 88 -> writes addr0=0x44332211 and addr1=0x88776655 with wstrb F; cpu_rst_n rises after the second i_ready.
REQ-032 s_valid toggled 1-0-1 each cycle, boot_nwords=1 -> exactly one write; no byte is lost or duplicated.
REQ-033 BOOT_CHECKSUM_EN, bytes 01 02 03 04 plus checksum 0A -> DONE; with checksum 0B instead -> ERROR, boot_err=1, cpu_rst_n=0.
REQ-034 In DONE, cpu_i_valid=1 with cpu_i_addr=1 -> i_addr=1, i_wstrb=0; cpu_i_rdata equals i_rdata when cpu_i_ready=1.
REQ-035 rst_n pulsed low during WRITE -> all outputs take reset values immediately; a new boot_start completes normally.
REQ-036 boot_nwords=0 -> no SRAM write; DONE reached within 2 cycles (without checksum).

Source files
------------

// File: rtl/sram_boot_loader.sv
// Boot loader: receives a little-endian byte stream, writes 32-bit words into the SRAM instruction
// port, then hands that port to the CPU. Optional image checksum when BOOT_CHECKSUM_EN is defined.
module sram_boot_loader #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   boot_start,
    input  logic [SRAM_ADDR_W-3:0] boot_nwords,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    output logic                   s_ready,
    output logic                   i_valid,
    output logic [SRAM_ADDR_W-3:0] i_addr,
    output logic [DATA_W-1:0]      i_wdata,
    output logic [3:0]             i_wstrb,
    input  logic [DATA_W-1:0]      i_rdata,
    input  logic                   i_ready,
    input  logic                   cpu_i_valid,
    input  logic [SRAM_ADDR_W-3:0] cpu_i_addr,
    output logic [DATA_W-1:0]      cpu_i_rdata,
    output logic                   cpu_i_ready,
    output logic                   cpu_rst_n,
    output logic                   boot_busy,
    output logic                   boot_done,
    output logic                   boot_err
);
    localparam int WA_W = SRAM_ADDR_W - 2;

    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERROR} state_t;

    state_t            state, state_nxt;
    logic [WA_W-1:0]   nwords;
    logic [WA_W-1:0]   word_cnt;
    logic [WA_W-1:0]   cnt_inc;
    logic [1:0]        byte_cnt;
    logic [DATA_W-1:0] word_buf;
    logic              byte_xfer;
    logic              start_ok;
    state_t            load_state;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign byte_xfer  = s_valid & s_ready;
    assign start_ok   = boot_start & ((state == IDLE) | (state == DONE) | (state == ERROR));
    assign cnt_inc    = word_cnt + WA_W'(1);
    assign load_state = (boot_nwords == '0) ? CHECK : RECV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        i_valid     = 1'b0;
        i_addr      = '0;
        i_wdata     = '0;
        i_wstrb     = '0;
        cpu_i_rdata = '0;
        cpu_i_ready = 1'b0;
        cpu_rst_n   = 1'b0;
        boot_busy   = 1'b0;
        boot_done   = 1'b0;
        boot_err    = 1'b0;
        case (state)
            IDLE: begin
                if (boot_start) state_nxt = load_state;
            end
            RECV: begin
                s_ready   = 1'b1;
                boot_busy = 1'b1;
                if (byte_xfer && byte_cnt == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                // i_ready arrives one cycle after the request, so it also retires i_valid
                boot_busy = 1'b1;
                i_valid   = ~i_ready;
                i_addr    = word_cnt;
                i_wdata   = word_buf;
                i_wstrb   = 4'hF;
                if (i_ready) state_nxt = (cnt_inc == nwords) ? CHECK : RECV;
            end
            CHECK: begin
                boot_busy = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                s_ready = 1'b1;
                if (byte_xfer) state_nxt = (s_data == csum) ? DONE : ERROR;
`else
                state_nxt = DONE;
`endif
            end
            DONE: begin
                cpu_rst_n   = 1'b1;
                boot_done   = 1'b1;
                i_valid     = cpu_i_valid;
                i_addr      = cpu_i_addr;
                cpu_i_rdata = i_rdata;
                cpu_i_ready = i_ready;
                if (boot_start) state_nxt = load_state;
            end
            ERROR: begin
                boot_err = 1'b1;
                if (boot_start) state_nxt = load_state;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nwords   <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum     <= '0;
`endif
        end else if (start_ok) begin
            nwords   <= boot_nwords;
            word_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum     <= '0;
`endif
        end else if (state == RECV && byte_xfer) begin
            // shifting right lands the first byte of each word in bits 7:0
            word_buf <= {s_data, word_buf[DATA_W-1:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            csum     <= csum + s_data;
`endif
        end else if (state == WRITE && i_ready) begin
            word_cnt <= cnt_inc;
        end
    end
endmodule
